// File: rtl/voice_sequencer.sv
// voice_sequencer: per-sample voice scheduler for the wavetable synth datapath.
// Each SAMPLE_TICK starts a sweep. One cycle clears the tone accumulator. Then one
// key slot is visited per clock, and the datapath load/mux controls for that slot are
// decoded from its envelope bits. When the sweep finishes, SAMPLE_VALID marks that
// TONE holds a complete mixed sample.
// Ports:
//   CLK, RESET         clock, synchronous active-high reset
//   SAMPLE_TICK        one-cycle audio sample strobe
//   EVT_VALID/KEY/ON   note events (always accepted)
//   ATT_OFF, NOTE_END  datapath status for the key currently presented
//   KEY                key slot presented to the datapath
//   LD_*, *_MUX, AMP_SEL, NOTE_ON, ATT_ON  datapath controls (combinational decode)
//   SAMPLE_VALID       one-cycle pulse at the end of a sweep
//   BUSY, OVERRUN      sweep in progress / sticky dropped-tick flag
//   ACTIVE_COUNT       active voices seen in the last completed sweep
module voice_sequencer #(
  parameter int unsigned NUM_KEYS = 128,
  parameter int unsigned KEY_W    = 7
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SAMPLE_TICK,
  input  logic             EVT_VALID,
  input  logic [KEY_W-1:0] EVT_KEY,
  input  logic             EVT_ON,
  input  logic             ATT_OFF,
  input  logic             NOTE_END,
  output logic [KEY_W-1:0] KEY,
  output logic             LD_PHASE,
  output logic             LD_AMP,
  output logic             LD_TONE,
  output logic             PHASE_MUX,
  output logic             AMP_SEL,
  output logic             TONE_MUX,
  output logic             NOTE_ON,
  output logic             ATT_ON,
  output logic             SAMPLE_VALID,
  output logic             BUSY,
  output logic             OVERRUN,
  output logic [7:0]       ACTIVE_COUNT
);

  localparam int unsigned CNT_W = 8;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [KEY_W-1:0]    r_key;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_active_count;
  logic                r_overrun;
  logic [NUM_KEYS-1:0] r_gate;
  logic [NUM_KEYS-1:0] r_att;
  logic [NUM_KEYS-1:0] r_active;
  logic [NUM_KEYS-1:0] r_pend;

  // Envelope bits of the slot being presented (pre-event values)
  logic w_pend;
  logic w_act;
  logic w_gate;
  logic w_att;

  assign w_pend = r_pend[r_key];
  assign w_act  = r_active[r_key];
  assign w_gate = r_gate[r_key];
  assign w_att  = r_att[r_key];

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (SAMPLE_TICK) w_next = S_CLEAR;
      S_CLEAR: w_next = S_SCAN;
      S_SCAN:  if (r_key == LAST_KEY) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode: controls follow the current slot so the datapath loads at the closing edge
  always_comb begin
    LD_PHASE     = 1'b0;
    LD_AMP       = 1'b0;
    LD_TONE      = 1'b0;
    PHASE_MUX    = 1'b0;
    AMP_SEL      = 1'b0;
    TONE_MUX     = 1'b0;
    NOTE_ON      = 1'b0;
    ATT_ON       = 1'b0;
    SAMPLE_VALID = 1'b0;
    BUSY         = (r_state != S_IDLE);
    case (r_state)
      S_CLEAR: begin
        LD_TONE  = 1'b1;
        TONE_MUX = 1'b0;
      end
      S_SCAN: begin
        if (w_pend) begin
          // Init cycle: zero phase and amplitude, contribute nothing to the mix
          LD_PHASE  = 1'b1;
          PHASE_MUX = 1'b0;
          LD_AMP    = 1'b1;
          AMP_SEL   = 1'b1;
        end else if (w_act) begin
          LD_PHASE  = 1'b1;
          LD_AMP    = 1'b1;
          LD_TONE   = 1'b1;
          PHASE_MUX = 1'b1;
          AMP_SEL   = 1'b0;
          TONE_MUX  = 1'b1;
          NOTE_ON   = w_gate;
          ATT_ON    = w_att;
        end
      end
      S_DONE:  SAMPLE_VALID = 1'b1;
      default: ;
    endcase
  end

  // Key counter: restarts in CLEAR, holds its last value once the sweep ends
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key <= '0;
    end else if (r_state == S_CLEAR) begin
      r_key <= '0;
    end else if ((r_state == S_SCAN) && (r_key != LAST_KEY)) begin
      r_key <= r_key + KEY_W'(1);
    end
  end

  // Active-voice tally for the running sweep, published in DONE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt          <= '0;
      r_active_count <= '0;
    end else begin
      case (r_state)
        S_CLEAR: r_cnt <= '0;
        S_SCAN:  if (w_act) r_cnt <= r_cnt + CNT_W'(1);
        S_DONE:  r_active_count <= r_cnt;
        default: ;
      endcase
    end
  end

  // Sticky flag for ticks that arrive while a sweep is still running
  always_ff @(posedge CLK) begin
    if (RESET)                                  r_overrun <= 1'b0;
    else if (SAMPLE_TICK && (r_state != S_IDLE)) r_overrun <= 1'b1;
  end

  // Per-key envelope bits. The event writes come after the scan updates so they take
  // priority when both target the same key in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_gate   <= '0;
      r_att    <= '0;
      r_active <= '0;
      r_pend   <= '0;
    end else begin
      if (r_state == S_SCAN) begin
        if (w_pend) begin
          r_pend[r_key] <= 1'b0;
        end else if (w_act) begin
          if (w_att && ATT_OFF) r_att[r_key]    <= 1'b0;
          if (NOTE_END)         r_active[r_key] <= 1'b0;
        end
      end
      if (EVT_VALID) begin
        if (EVT_ON) begin
          // Note-on and retrigger both restart the voice from zero
          r_gate[EVT_KEY]   <= 1'b1;
          r_att[EVT_KEY]    <= 1'b1;
          r_active[EVT_KEY] <= 1'b1;
          r_pend[EVT_KEY]   <= 1'b1;
        end else if (r_active[EVT_KEY]) begin
          r_gate[EVT_KEY] <= 1'b0;
        end
      end
    end
  end

  assign KEY          = r_key;
  assign OVERRUN      = r_overrun;
  assign ACTIVE_COUNT = r_active_count;

endmodule

// File: doc/voice_sequencer.md
Name: voice_sequencer

Overview:
- Per-sample voice scheduler for the wavetable synth datapath.
- On each audio sample tick it clears the tone accumulator, then sweeps all 128 key slots, one per clock.
- For each slot it drives KEY and the load/mux controls, and tracks per-key envelope state (gate, attack, active, init-pending).
- Accepts note events from the NIOS II/USB MIDI side and hands a finished mixed sample to the audio output path.

Parameters:
NUM_KEYS, 128, number of key slots swept per sample
KEY_W, 7, key index width (log2 NUM_KEYS)

Ports:
CLK  in  1  clock
RESET  in  1  reset, synchronous, active-high
SAMPLE_TICK  in  1  one-cycle audio sample strobe
EVT_VALID  in  1  note event strobe; always accepted, no backpressure
EVT_KEY  in  7  event key number
EVT_ON  in  1  1 = note-on, 0 = note-off
ATT_OFF  in  1  datapath: attack finished for current KEY
NOTE_END  in  1  datapath: release finished for current KEY
KEY  out  7  key slot presented to datapath
LD_PHASE, LD_AMP, LD_TONE  out  1 each  datapath register loads
PHASE_MUX  out  1  0 = load zero phase, 1 = advance phase
AMP_SEL  out  1  1 = load zero amplitude, 0 = envelope step
TONE_MUX  out  1  0 = clear tone accumulator, 1 = accumulate
NOTE_ON  out  1  gate bit of current KEY
ATT_ON  out  1  attack bit of current KEY
SAMPLE_VALID  out  1  one-cycle pulse: datapath TONE holds a complete sample
BUSY  out  1  sweep in progress (state != IDLE)
OVERRUN  out  1  sticky: a tick arrived while BUSY
ACTIVE_COUNT  out  8  active voices counted in the last completed sweep

Behaviour:
- Per-key state bits: gate[k], att[k], active[k], pend[k]. All are cleared by RESET.
- FSM states: IDLE, CLEAR, SCAN, DONE.
- IDLE: on SAMPLE_TICK, go to CLEAR.
- CLEAR (1 cycle): LD_TONE=1, TONE_MUX=0. Key counter is set to 0. Go to SCAN.
- SCAN (NUM_KEYS cycles, KEY = counter 0..127): controls are a combinational decode of the current key's bits, so the datapath loads at the closing edge.
  - pend[k]=1: LD_PHASE=1, PHASE_MUX=0, LD_AMP=1, AMP_SEL=1, LD_TONE=0. Clear pend[k].
  - else active[k]=1: LD_PHASE=LD_AMP=LD_TONE=1, PHASE_MUX=1, AMP_SEL=0, TONE_MUX=1, NOTE_ON=gate[k], ATT_ON=att[k].
    - If att[k] and ATT_OFF: clear att[k].
    - If NOTE_END: clear active[k].
  - else: all loads 0.
  - At counter 127, go to DONE.
- DONE (1 cycle): SAMPLE_VALID=1. Latch ACTIVE_COUNT = number of slots with active[k]=1 at the start of their scan slot. Go to IDLE.
- Latency: tick sampled at edge 0 gives SAMPLE_VALID high in cycle NUM_KEYS+2 (130). Minimum tick spacing is 131 cycles.
- SAMPLE_TICK while BUSY: the tick is dropped, OVERRUN is set, and the sweep continues. Only RESET clears OVERRUN.
- Note-on event: gate=att=active=pend=1. A retrigger of an already-active key behaves the same, so the voice restarts from zero phase and amplitude.
- Note-off event: gate=0; the other bits are unchanged, so the voice enters release. Note-off for an inactive key has no effect.
- Event for the same key in the same cycle that the key is in its SCAN slot: controls for that cycle use the pre-event bits, and the event's bit updates win over the scan's clear/update.
- Idle control values: all outputs 0 outside SCAN/CLEAR, and KEY holds its last value.
- Reset values: KEY=0, all strobes 0, ACTIVE_COUNT=0, OVERRUN=0, state IDLE.
- RESET mid-sweep aborts immediately: no SAMPLE_VALID, all key bits cleared.

Test Plan:
- Reset, then tick with no events → LD_TONE/TONE_MUX=0 in cycle 1; no LD_PHASE/LD_AMP for 128 cycles; SAMPLE_VALID in cycle 130; ACTIVE_COUNT=0.
- Note-on key 60, then two ticks → sweep 1: slot 60 has PHASE_MUX=0, AMP_SEL=1, LD_TONE=0. Sweep 2: slot 60 has all loads=1, NOTE_ON=1, ATT_ON=1. ACTIVE_COUNT=1.
- Key 60 with ATT_OFF forced high in its slot → next sweep ATT_ON=0. Then note-off plus NOTE_END in its slot → next sweep key 60 has no loads; ACTIVE_COUNT=0 after the following sweep.
- Tick issued 50 cycles after the previous tick → OVERRUN=1; exactly one SAMPLE_VALID is produced, at cycle 130 of the first sweep.
- Note-on key 10 presented in the same cycle KEY=10 during an active release → pend/gate/att set; the next sweep performs the init cycle on slot 10.
- RESET asserted at KEY=64 → outputs return to reset values the next cycle, no SAMPLE_VALID; a subsequent tick sweeps with ACTIVE_COUNT=0.
